// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One operation takes 34 cycles from the start edge to the done pulse. The
// unit always spends the same number of cycles, whatever the operand values.
// Signed operations run on operand magnitudes. The sign is fixed up in the
// final cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [5:0] LAST_ITER = 6'd32;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [1:0]  op_q;
  logic [31:0] m_q;
  logic [31:0] acc_q;
  logic [31:0] low_q;
  logic [31:0] rs_q;
  logic        neg_q;
  logic        rem_neg_q;

  logic        in_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [31:0] acc_next;
  logic [31:0] low_next;

  logic [63:0] prod_mag;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        div_zero;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  logic        accept;
  logic        iterate;

  assign accept  = (state == S_IDLE) && start;
  assign iterate = (state == S_RUN) && (count != LAST_ITER);

  // Operand sign detection and magnitude extraction at the start edge.
  // The magnitude of 0x80000000 is 0x80000000 as an unsigned value.
  always_comb begin
    in_signed = ~op[0];
    a_neg     = in_signed & rs_data[31];
    b_neg     = in_signed & rt_data[31];
    a_mag     = a_neg ? (~rs_data + 32'd1) : rs_data;
    b_mag     = b_neg ? (~rt_data + 32'd1) : rt_data;
  end

  // One iteration step.
  // Multiply: shift-add. {acc_q, low_q} holds the partial product and the
  // remaining multiplier bits.
  // Divide: restoring division. acc_q is the partial remainder, and low_q
  // shifts the dividend out while the quotient bits shift in.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, m_q} : 33'd0);
    div_shift = {acc_q, low_q[31]};
    div_ge    = (div_shift >= {1'b0, m_q});
    div_diff  = div_shift[31:0] - m_q;
    acc_next  = acc_q;
    low_next  = low_q;
    if (op_q[1]) begin
      if (div_ge) begin
        acc_next = div_diff;
        low_next = {low_q[30:0], 1'b1};
      end else begin
        acc_next = div_shift[31:0];
        low_next = {low_q[30:0], 1'b0};
      end
    end else begin
      acc_next = mul_sum[32:1];
      low_next = {mul_sum[0], low_q[31:1]};
    end
  end

  // Sign correction and result selection, used only in the FIX state.
  // Division by zero bypasses the datapath so that LO becomes all ones and
  // HI returns the latched dividend unchanged.
  always_comb begin
    prod_mag = {acc_q, low_q};
    prod_fix = ((op_q == OP_MULT) && neg_q) ? (~prod_mag + 64'd1) : prod_mag;
    quo_fix  = ((op_q == OP_DIV) && neg_q) ? (~low_q + 32'd1) : low_q;
    rem_fix  = ((op_q == OP_DIV) && rem_neg_q) ? (~acc_q + 32'd1) : acc_q;
    div_zero = (m_q == 32'd0);
    hi_res   = prod_fix[63:32];
    lo_res   = prod_fix[31:0];
    if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
      if (div_zero) begin
        hi_res = rs_q;
        lo_res = 32'hFFFF_FFFF;
      end else begin
        hi_res = rem_fix;
        lo_res = quo_fix;
      end
    end
  end

  // Control FSM: it sequences IDLE -> RUN -> FIX and owns busy, done, the
  // iteration counter and the architectural HI/LO registers.
  // In IDLE, a start takes priority over any MTHI/MTLO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= 6'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            count <= 6'd0;
            busy  <= 1'b1;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          if (count == LAST_ITER) begin
            state <= S_FIX;
          end else begin
            count <= count + 6'd1;
          end
        end
        S_FIX: begin
          hi    <= hi_res;
          lo    <= lo_res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: operand capture on an accepted start, then one
  // iteration on each RUN cycle until the counter reaches its final value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MULTU;
      m_q       <= 32'd0;
      acc_q     <= 32'd0;
      low_q     <= 32'd0;
      rs_q      <= 32'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (accept) begin
      op_q      <= op;
      rs_q      <= rs_data;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      acc_q     <= 32'd0;
      if (op[1]) begin
        m_q   <= b_mag;
        low_q <= a_mag;
      end else begin
        m_q   <= a_mag;
        low_q <= b_mag;
      end
    end else if (iterate) begin
      acc_q <= acc_next;
      low_q <= low_next;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for MTHI/MTLO, start-while-busy and reset mid-operation.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  mult_div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model written as plain arithmetic on the operation's meaning.
  function automatic void refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sr;
    logic [63:0]        ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    eh = 32'd0;
    el = 32'd0;
    case (o)
      2'b00: begin
        sr = sa * sb;
        eh = sr[63:32];
        el = sr[31:0];
      end
      2'b01: begin
        ur = {32'd0, a} * {32'd0, b};
        eh = ur[63:32];
        el = ur[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else begin
          sr = sa / sb;
          el = sr[31:0];
          sr = sa % sb;
          eh = sr[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  // Launch one operation, then follow it cycle by cycle until done or a bound.
  // An optional MTHI/MTLO write accompanies the start, and an optional
  // start+write intrusion can be pulsed mid-operation.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input bit write_with_start, input int intrude_at,
                               output int done_cycle, output int busy_cycles,
                               output logic [31:0] hi_at_start, output logic [31:0] lo_at_start);
    @(negedge clk);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    hi_we   = write_with_start;
    lo_we   = write_with_start;
    wdata   = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start   = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    op      = 2'($urandom);
    rs_data = $urandom;
    rt_data = $urandom;
    hi_at_start = hi;
    lo_at_start = lo;
    busy_cycles = busy ? 1 : 0;
    done_cycle  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        done_cycle = k;
        break;
      end
      if (k == intrude_at) begin
        start = 1'b1;
        op    = 2'b10;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0BAD_0BAD;
      end
    end
  endtask

  task automatic runCase(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit wr, input int intrude_at);
    int          dc;
    int          bc;
    logic [31:0] h0;
    logic [31:0] l0;
    applyStimulus(o, a, b, wr, intrude_at, dc, bc, h0, l0);
    checkOutput($sformatf("%s hi held at start", name), h0, cur_hi);
    checkOutput($sformatf("%s lo held at start", name), l0, cur_lo);
    checkOutput($sformatf("%s done latency", name), dc, 32'd34);
    checkOutput($sformatf("%s busy cycles", name), bc, 32'd34);
    checkOutput($sformatf("%s hi", name), hi, exp_hi);
    checkOutput($sformatf("%s lo", name), lo, exp_lo);
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s done one cycle", name), {31'd0, done}, 32'd0);
    checkOutput($sformatf("%s busy after", name), {31'd0, busy}, 32'd0);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] eh;
    logic [31:0] el;
    int          done_seen;

    vecs[0] = '{"multu max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult -3x7",     2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{"div -7/2",      2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu 100/0",    2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{"div min/-1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{"div 7/-2",      2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{"div -5/0",      2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{"mult min*min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{"divu max/3",    2'b11, 32'hFFFF_FFFF, 32'd3,         32'h0000_0000, 32'h5555_5555};
    vecs[9] = '{"multu 0*x",     2'b01, 32'd0,         32'h0001_2345, 32'h0000_0000, 32'h0000_0000};

    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = 32'd0;
    rt_data = 32'd0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wdata   = 32'd0;
    cur_hi  = 32'd0;
    cur_lo  = 32'd0;

    #12;
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      runCase(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0, 0);
    end

    // MTHI and MTLO in IDLE.
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    checkOutput("mthi hi", hi, 32'hCAFE_F00D);
    checkOutput("mthi lo kept", lo, cur_lo);
    cur_hi = 32'hCAFE_F00D;
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h0000_5A5A;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    checkOutput("mtlo lo", lo, 32'h0000_5A5A);
    checkOutput("mtlo hi kept", hi, cur_hi);
    cur_lo = 32'h0000_5A5A;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle hold hi", hi, cur_hi);
    checkOutput("idle hold lo", lo, cur_lo);

    // A start together with a write: the start wins and the write is dropped.
    runCase("start+write", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1, 0);

    // Start and write pulsed while busy are both ignored.
    runCase("multu 5x6 intruded", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 10);

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      refModel(ro, ra, rb, eh, el);
      runCase($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, eh, el, 1'($urandom_range(0, 1)), 0);
    end

    // MTLO, start, then reset mid-operation: nothing partial, no done.
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    checkOutput("pre-reset mtlo", lo, 32'h0000_1234);
    @(negedge clk);
    op      = 2'b01;
    rs_data = 32'd1000;
    rt_data = 32'd1000;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
    checkOutput("mid reset hi", hi, 32'd0);
    checkOutput("mid reset lo", lo, 32'd0);
    checkOutput("mid reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("no done after reset", done_seen, 32'd0);
    checkOutput("post reset busy", {31'd0, busy}, 32'd0);
    checkOutput("post reset lo", lo, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;

    // The first start after reset is accepted normally.
    runCase("after reset divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock, the same clock as the register file.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  input  32  operand A (multiplicand or dividend), driven from register-file read_data_1.
REQ-007 rt_data  input  32  operand B (multiplier or divisor), driven from register-file read_data_2.
REQ-008 hi_we / lo_we  input  1 each  MTHI / MTLO write strobes.
REQ-009 wdata  input  32  data for MTHI / MTLO.
REQ-010 hi / lo  output  32 each  registered HI and LO results, read by MFHI / MFLO.
REQ-011 busy  output  1  operation in progress; upstream SHALL stall MFHI, MFLO, MULT and DIV while busy is high.
REQ-012 done  output  1  one-cycle pulse marking that hi and lo have just been updated.

Function
REQ-013 The state machine SHALL have exactly these states: IDLE, RUN, FIX.
REQ-014 In IDLE, start=1 SHALL latch op and both operands, clear the 6-bit iteration counter, and move to RUN on that edge (the start edge).
REQ-015 In RUN, each edge SHALL perform one iteration and increment the counter: a shift-add step for multiply, a restoring shift-subtract step for divide. After 32 iterations the block SHALL move to FIX.
REQ-016 In FIX, the block SHALL apply sign correction, write hi and lo, return to IDLE, and assert done for the following cycle.
REQ-017 Fixed latency: hi, lo and done SHALL be valid 34 edges after the start edge, independent of operand values.
REQ-018 busy SHALL equal (state != IDLE) and SHALL be registered, with no combinational path from start.
REQ-019 done SHALL be high for exactly one cycle per completed operation and low at all other times.
REQ-020 MULT and DIV SHALL operate on two's-complement magnitudes; MULTU and DIVU SHALL operate on raw unsigned values.
REQ-021 Multiply result: {hi,lo} = 64-bit product; for MULT, negate the product if the operand signs differ.
REQ-022 Divide result: lo = quotient, hi = remainder. The quotient SHALL be negated if the signs differ (DIV only). The remainder SHALL take the sign of the dividend (DIV only).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000, with no error flag.
REQ-024 Divide by zero (either signedness) SHALL yield lo=0xFFFFFFFF and hi=rs_data as latched, with normal latency.
REQ-025 start while busy SHALL be ignored, and the running operation SHALL be unaffected.
REQ-026 hi_we / lo_we in IDLE SHALL write wdata to hi / lo on that edge; they SHALL be ignored while busy.
REQ-027 If start and hi_we/lo_we are both high in IDLE, start SHALL take effect and the write SHALL be dropped.
REQ-028 Operand inputs SHALL be don't-care after the start edge; only the latched copies are used.
REQ-029 hi and lo SHALL hold their values between updates; only the FIX state or an MTHI/MTLO write SHALL change them.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, busy=0 and done=0, regardless of clk.
REQ-031 A reset during RUN or FIX SHALL abandon the operation, no partial result SHALL reach hi or lo, and no done pulse SHALL follow.
REQ-032 After rst_n deasserts, the first start sampled SHALL be accepted normally.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 edges hi=0xFFFFFFFE, lo=0x00000001, with one done pulse.
REQ-034 MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 34 cycles.
REQ-035 DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 Issue MULTU 5x6, then pulse start with op=DIV and hi_we=1 at cycle 10 -> result hi=0, lo=30; the second start and the write are both ignored.
REQ-038 MTLO 0x1234 in IDLE, then start MULTU, then rst_n low at cycle 20 -> hi=lo=0 and busy=0 immediately; no done pulse in the following 40 cycles.
